// File: rtl/divmod_pkg.sv
// rtl/divmod_pkg.sv - shared FSM type and constants for the iterative divider
package divmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divmod_state_t;

    // Widest operand supported; DIV0_QUOTIENT is sliced down to the instance width.
    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divmod_step.sv
// rtl/divmod_step.sv - one combinational restoring shift-subtract step
module divmod_step
    import divmod_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted  = {rem[WIDTH-1:0], dvd_msb};
    // Compare on the full partial remainder so its top bit still participates.
    assign q_bit    = ({rem, dvd_msb} >= {2'b00, divisor});
    assign rem_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/divmod_unit.sv
// rtl/divmod_unit.sv - iterative restoring divider with quotient/remainder and signed mode
module divmod_unit
    import divmod_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    divmod_state_t    state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic             sign_q;
    logic             sign_r;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    assign op_signed = SIGNED_EN && signed_op;
    assign a_neg     = op_signed && a[WIDTH-1];
    assign b_neg     = op_signed && b[WIDTH-1];
    // MIN maps onto itself, which is the correct unsigned magnitude.
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign accept    = start && ready;

    divmod_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        if (b == '0) begin
                            quotient    <= DIV0_QUOTIENT[WIDTH-1:0];
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd    <= a_mag;
                            dvs    <= b_mag;
                            rem    <= '0;
                            sign_q <= a_neg ^ b_neg;
                            sign_r <= a_neg;
                            cnt    <= CW'(WIDTH);
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    // The dividend register fills with quotient bits as it drains.
                    dvd <= {dvd[WIDTH-2:0], q_bit};
                    rem <= rem_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= sign_q ? -dvd : dvd;
                    remainder   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_unit.sv
// tb/tb_divmod_unit.sv - table-driven bench for divmod_unit (32-bit signed and 8-bit unsigned)
module tb_divmod_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, sop32, ready32, busy32, done32, dz32;
    logic [31:0] a32, b32, q32, r32;
    logic        start8, sop8, ready8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;

    int checks = 0;
    int errors = 0;

    divmod_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .signed_op(sop32),
        .a(a32), .b(b32), .ready(ready32), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dz32)
    );

    divmod_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_op(sop8),
        .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    typedef struct {
        bit          w8;
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the sampling edge N.
    task automatic launch(input bit w8, input logic sop, input logic [31:0] av, input logic [31:0] bv);
        if (w8) begin
            start8 = 1'b1; sop8 = sop; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = 1'b1; sop32 = sop; a32 = av; b32 = bv;
        end
        @(posedge clk);
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic wait_done(input bit w8, output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (w8 ? done8 : done32) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] q_act, r_act;
        logic        dz_act, busy_act;

        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34};
        vecs[3]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34};
        vecs[4]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
        vecs[5]  = '{1'b0, 1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 34};
        vecs[6]  = '{1'b0, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 34};
        vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1};
        vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 34};
        vecs[10] = '{1'b1, 1'b0, 32'd200,        32'd13,         32'd15,         32'd5,          1'b0, 10};
        vecs[11] = '{1'b1, 1'b1, 32'd200,        32'd13,         32'd15,         32'd5,          1'b0, 10};
        vecs[12] = '{1'b1, 1'b0, 32'd200,        32'd0,          32'h0000_00FF,  32'd200,        1'b1, 1};

        reset = 1'b1;
        start32 = 1'b0; sop32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sop8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("reset_ready", {31'b0, ready32}, 32'd1);
        chk("reset_busy",  {31'b0, busy32},  32'd0);
        chk("reset_done",  {31'b0, done32},  32'd0);
        chk("reset_q",     q32,              32'd0);
        chk("reset_r",     r32,              32'd0);
        chk("reset_dz",    {31'b0, dz32},    32'd0);
        chk("reset_ready8", {31'b0, ready8}, 32'd1);

        // Each vector starts in the previous done cycle, so acceptance there is exercised too.
        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].w8, vecs[i].sop, vecs[i].a, vecs[i].b);
            busy_act = vecs[i].w8 ? busy8 : busy32;
            chk($sformatf("v%0d_accept_busy", i), {31'b0, busy_act}, 32'd1);
            wait_done(vecs[i].w8, lat);
            q_act    = vecs[i].w8 ? {24'b0, q8} : q32;
            r_act    = vecs[i].w8 ? {24'b0, r8} : r32;
            dz_act   = vecs[i].w8 ? dz8 : dz32;
            busy_act = vecs[i].w8 ? busy8 : busy32;
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_quotient", i), q_act, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), r_act, vecs[i].r);
            chk($sformatf("v%0d_div_by_zero", i), {31'b0, dz_act}, {31'b0, vecs[i].dz});
            chk($sformatf("v%0d_done_busy", i), {31'b0, busy_act}, 32'd0);
        end

        // start pulsed mid-CALC with different operands must be ignored.
        @(negedge clk);
        launch(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait_done(1'b0, lat);
        chk("poke_latency",   lat,           32'd29);
        chk("poke_quotient",  q32,           32'd14);
        chk("poke_remainder", r32,           32'd2);
        chk("poke_dz",        {31'b0, dz32}, 32'd0);

        // Reset around CALC cycle 10 aborts with no done pulse.
        launch(1'b0, 1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", {31'b0, ready32}, 32'd1);
        chk("abort_busy",  {31'b0, busy32},  32'd0);
        chk("abort_q",     q32,              32'd0);
        chk("abort_r",     r32,              32'd0);
        chk("abort_dz",    {31'b0, dz32},    32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done32) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
